// File: rtl/legv8_decode_stage.sv
// legv8_decode_stage: LEGv8 instruction decoder with a registered valid/ready output stage (optional LOAD_USE_STALL_EN hazard unit)
module legv8_decode_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [31:0]                instruction,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       unconditionalBranch,
    output logic                       branch,
    output logic                       memRead,
    output logic                       memToReg,
    output logic                       memWrite,
    output logic                       aluSRC,
    output logic                       regWriteFlag,
    output logic [3:0]                 aluControlCode,
    output logic [4:0]                 readRegister1,
    output logic [4:0]                 readRegister2,
    output logic [4:0]                 writeRegister,
    output logic [DATA_WIDTH-1:0]      immediate,
    output logic                       illegal,
    output logic [STALL_CNT_WIDTH-1:0] stallCount
);
    typedef enum logic {EMPTY, FULL} stateT;
    stateT state;
    logic isLdur, isStur, isAdd, isSub, isAnd, isOrr, isCbz, isB, isR, usesRm;
    logic accept, transfer, hazard;
    logic [3:0] dAlu;
    logic [4:0] dRr2;
    logic [DATA_WIDTH-1:0] dImm;

    assign isLdur = instruction[31:21] == 11'b11111000010;
    assign isStur = instruction[31:21] == 11'b11111000000;
    assign isAdd = instruction[31:21] == 11'b10001011000;
    assign isSub = instruction[31:21] == 11'b11001011000;
    assign isAnd = instruction[31:21] == 11'b10001010000;
    assign isOrr = instruction[31:21] == 11'b10101010000;
    assign isCbz = instruction[31:24] == 8'b10110100;
    assign isB = instruction[31:26] == 6'b000101;
    assign isR = isAdd || isSub || isAnd || isOrr;
    assign usesRm = isR || isStur || isCbz;
    assign dRr2 = (isStur || isCbz) ? instruction[4:0] : instruction[20:16];
    assign dAlu = isOrr ? 4'b0001 : (isAdd || isLdur || isStur) ? 4'b0010 : isSub ? 4'b0110 : isCbz ? 4'b0111 : 4'b0000;
    assign dImm = (isLdur || isStur) ? {{(DATA_WIDTH-9){instruction[20]}}, instruction[20:12]}
                : isCbz ? {{(DATA_WIDTH-19){instruction[23]}}, instruction[23:5]}
                : isB ? {{(DATA_WIDTH-26){instruction[25]}}, instruction[25:0]}
                : '0;

    assign outValid = state == FULL;
    assign inReady = (!outValid || outReady) && !hazard;
    assign accept = inValid && inReady;
    assign transfer = outValid && outReady;

`ifdef LOAD_USE_STALL_EN
    logic bubble, heldHit, bubbleHit;
    logic [4:0] bubbleDest;
    // incoming instruction sources a register still being loaded by the held or just-departed LDUR
    always_comb begin
        heldHit = writeRegister != 5'd31 && (writeRegister == instruction[9:5] || (usesRm && writeRegister == dRr2));
        bubbleHit = bubbleDest != 5'd31 && (bubbleDest == instruction[9:5] || (usesRm && bubbleDest == dRr2));
        hazard = (outValid && memRead && heldHit) || (bubble && bubbleHit);
    end
    // a stall already taken in the LDUR transfer cycle supplies the required gap, so no further bubble is needed then
    always_ff @(posedge clock) begin
        if (reset) begin
            bubble <= 1'b0;
            bubbleDest <= '0;
            stallCount <= '0;
        end else begin
            bubble <= transfer && memRead && !(inValid && hazard);
            if (transfer && memRead)
                bubbleDest <= writeRegister;
            if (inValid && hazard && !(&stallCount))
                stallCount <= stallCount + 1'b1;
        end
    end
`else
    assign hazard = 1'b0;
    assign stallCount = '0;
`endif

    // output stage: load the decoded bundle on accept, empty on transfer without a new accept
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            unconditionalBranch <= 1'b0;
            branch <= 1'b0;
            memRead <= 1'b0;
            memToReg <= 1'b0;
            memWrite <= 1'b0;
            aluSRC <= 1'b0;
            regWriteFlag <= 1'b0;
            aluControlCode <= '0;
            readRegister1 <= '0;
            readRegister2 <= '0;
            writeRegister <= '0;
            immediate <= '0;
            illegal <= 1'b0;
        end else if (accept) begin
            state <= FULL;
            unconditionalBranch <= isB;
            branch <= isCbz;
            memRead <= isLdur;
            memToReg <= isLdur;
            memWrite <= isStur;
            aluSRC <= isLdur || isStur;
            regWriteFlag <= isLdur || isR;
            aluControlCode <= dAlu;
            readRegister1 <= instruction[9:5];
            readRegister2 <= dRr2;
            writeRegister <= instruction[4:0];
            immediate <= dImm;
            illegal <= !(isLdur || isStur || isR || isCbz || isB);
        end else if (transfer) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_legv8_decode_stage.sv
// tb_legv8_decode_stage: scoreboard bench for legv8_decode_stage (stall expectations follow LOAD_USE_STALL_EN)
module tb_legv8_decode_stage;
`ifdef LOAD_USE_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif
    typedef struct packed {
        logic [6:0]  f;
        logic [3:0]  alu;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wr;
        logic [63:0] imm;
        logic        ill;
    } bundleT;

    logic clock = 0, reset = 1, inValid = 0, outReady = 1;
    logic [31:0] instruction = '0;
    logic inReady, outValid, unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag, illegal;
    logic [3:0] aluControlCode;
    logic [4:0] readRegister1, readRegister2, writeRegister;
    logic [63:0] immediate;
    logic [15:0] stallCount;
    int checks = 0, errors = 0;
    bundleT q[$];

    legv8_decode_stage dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .instruction(instruction),
        .outValid(outValid), .outReady(outReady), .unconditionalBranch(unconditionalBranch), .branch(branch),
        .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite), .aluSRC(aluSRC), .regWriteFlag(regWriteFlag),
        .aluControlCode(aluControlCode), .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister), .immediate(immediate), .illegal(illegal), .stallCount(stallCount)
    );

    always #5 clock = ~clock;

    function automatic bundleT mk(input logic [6:0] f, input logic [3:0] a, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] wr, input logic [63:0] imm, input logic ill);
        return {f, a, r1, r2, wr, imm, ill};
    endfunction

    function automatic bundleT obs();
        return {unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag,
                aluControlCode, readRegister1, readRegister2, writeRegister, immediate, illegal};
    endfunction

    function automatic bundleT pop();
        bundleT e = '1;
        if (q.size() != 0) e = q.pop_front();
        return e;
    endfunction

    task automatic drain();
        outReady = 1; inValid = 0;
        repeat (2) @(negedge clock);
    endtask

    task automatic issue(input logic [31:0] ins, input bundleT e);
        int w = 0;
        instruction = ins; inValid = 1; q.push_back(e); #1;
        while (!inReady && w < 8) begin @(negedge clock); #1; w++; end
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL accept_timeout got inReady=%b exp 1", inReady); end
        @(negedge clock);
        inValid = 0;
    endtask

    task automatic test_reset();
        reset = 1; outReady = 1; inValid = 0;
        repeat (2) @(negedge clock);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b exp 0", outValid); end
        checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_bundle got %h exp 0", obs()); end
        checks++; if (stallCount !== '0) begin errors++; $display("FAIL reset_stallCount got %0d exp 0", stallCount); end
        reset = 0;
        @(negedge clock);
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b exp 1", inReady); end
    endtask

    task automatic test_add();
        bundleT e;
        drain();
        issue(32'h8B030041, mk(7'b0000001, 4'b0010, 5'd2, 5'd3, 5'd1, 64'd0, 1'b0));
        e = pop();
        checks++; if (outValid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL add got v=%b %h exp %h", outValid, obs(), e); end
    endtask

    task automatic test_ldur();
        bundleT e;
        drain();
        issue(32'hF8408045, mk(7'b0011011, 4'b0010, 5'd2, 5'd0, 5'd5, 64'd8, 1'b0));
        e = pop();
        checks++; if (outValid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL ldur got v=%b %h exp %h", outValid, obs(), e); end
    endtask

    task automatic test_load_use();
        bundleT e;
        drain();
        issue(32'hF8408045, mk(7'b0011011, 4'b0010, 5'd2, 5'd0, 5'd5, 64'd8, 1'b0));
        e = pop();
        checks++; if (obs() !== e) begin errors++; $display("FAIL lu_ldur got %h exp %h", obs(), e); end
        instruction = 32'hCB0700A6; inValid = 1;
        q.push_back(mk(7'b0000001, 4'b0110, 5'd5, 5'd7, 5'd6, 64'd0, 1'b0));
        #1;
        checks++; if (inReady !== !STALL) begin errors++; $display("FAIL lu_inReady got %b exp %b", inReady, !STALL); end
        @(negedge clock);
        checks++; if (outValid !== !STALL) begin errors++; $display("FAIL lu_gap got %b exp %b", outValid, !STALL); end
        if (STALL) @(negedge clock);
        inValid = 0;
        e = pop();
        checks++; if (outValid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL lu_sub got v=%b %h exp %h", outValid, obs(), e); end
        checks++; if (stallCount !== 16'(STALL)) begin errors++; $display("FAIL lu_stallCount got %0d exp %0d", stallCount, STALL); end
    endtask

    task automatic test_back_to_back();
        bundleT e;
        logic [31:0] ins [4] = '{32'h8A030041, 32'hAA030041, 32'hF8010045, 32'hF85F8045};
        bundleT exp [4];
        exp[0] = mk(7'b0000001, 4'b0000, 5'd2, 5'd3, 5'd1, 64'd0, 1'b0);
        exp[1] = mk(7'b0000001, 4'b0001, 5'd2, 5'd3, 5'd1, 64'd0, 1'b0);
        exp[2] = mk(7'b0000110, 4'b0010, 5'd2, 5'd5, 5'd5, 64'd16, 1'b0);
        exp[3] = mk(7'b0011011, 4'b0010, 5'd2, 5'd31, 5'd5, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) begin
            instruction = ins[i]; inValid = 1; q.push_back(exp[i]);
            #1;
            checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady[%0d] got %b exp 1", i, inReady); end
            @(negedge clock);
            e = pop();
            checks++; if (outValid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL b2b[%0d] got v=%b %h exp %h", i, outValid, obs(), e); end
        end
        inValid = 0;
    endtask

    task automatic test_backpressure();
        bundleT e;
        drain();
        outReady = 0;
        issue(32'h17FFFFFC, mk(7'b1000000, 4'b0000, 5'd31, 5'd31, 5'd28, 64'hFFFFFFFFFFFFFFFC, 1'b0));
        e = pop();
        instruction = 32'h8B030041; inValid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (outValid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL bp_hold[%0d] got v=%b %h exp %h", i, outValid, obs(), e); end
            checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady[%0d] got %b exp 0", i, inReady); end
            @(negedge clock);
        end
        inValid = 0; outReady = 1;
        @(negedge clock);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", outValid); end
    endtask

    task automatic test_cbz_illegal();
        bundleT e;
        drain();
        issue(32'hB4000209, mk(7'b0100000, 4'b0111, 5'd16, 5'd9, 5'd9, 64'd16, 1'b0));
        e = pop();
        checks++; if (obs() !== e) begin errors++; $display("FAIL cbz got %h exp %h", obs(), e); end
        issue(32'h00000000, mk(7'b0000000, 4'b0000, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1));
        e = pop();
        checks++; if (outValid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL illegal got v=%b %h exp %h", outValid, obs(), e); end
    endtask

    task automatic test_reset_mid();
        bundleT e;
        drain();
        outReady = 0;
        issue(32'hF8408045, mk(7'b0011011, 4'b0010, 5'd2, 5'd0, 5'd5, 64'd8, 1'b0));
        e = pop();
        checks++; if (obs() !== e) begin errors++; $display("FAIL rm_held got %h exp %h", obs(), e); end
        reset = 1;
        @(negedge clock);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rm_outValid got %b exp 0", outValid); end
        checks++; if (obs() !== '0) begin errors++; $display("FAIL rm_bundle got %h exp 0", obs()); end
        checks++; if (stallCount !== '0) begin errors++; $display("FAIL rm_stallCount got %0d exp 0", stallCount); end
        reset = 0; outReady = 1;
        @(negedge clock);
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rm_inReady got %b exp 1", inReady); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur();
        test_load_use();
        test_back_to_back();
        test_backpressure();
        test_cbz_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
